pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register; next generation of the fixed MEM/WB register.
//  Carries an opaque payload, default the packed MEM->WB bundle, between any two stages.
//  Adds valid/ready flow control, synchronous flush, an optional 2-entry skid buffer with
//  registered in_ready, and a saturating stall counter. Used at IF/ID, ID/EX, EX/MEM, MEM/WB.
// PARAMETERS
//  PAYLOAD_W   200  payload bits (pipe_pkg::MEM_WB_W = 64+64+5+1+2+64)
//  SKID_EN     1    1: 2-entry skid, in_ready registered; 0: 1 entry, in_ready combinational
//  RESET_DATA  1    1: payload flops reset to 0; 0: only valid/control flops reset
//  CNT_W       16   stall counter width
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high reset
//  in_valid     in   1          upstream payload valid
//  in_ready     out  1          block can accept this cycle
//  in_data      in   PAYLOAD_W  upstream payload
//  out_valid    out  1          payload valid to downstream (registered)
//  out_ready    in   1          downstream accepts
//  out_data     out  PAYLOAD_W  payload to downstream (registered)
//  flush        in   1          discard all held entries (branch mispredict / trap)
//  occupancy    out  2          entries held: 0..2 (max 1 when SKID_EN=0)
//  stall_cnt    out  CNT_W      cycles with out_valid && !out_ready, saturating
//  stall_clr    in   1          synchronous clear of stall_cnt
// BEHAVIOUR
//  - Transfer: in when in_valid&&in_ready; out when out_valid&&out_ready. Latency 1 cycle.
//  - Reset (async): main_v=0, skid_v=0, out_valid=0, in_ready=0 (SKID_EN=1), occupancy=0,
//    stall_cnt=0; out_data=0 and skid data=0 if RESET_DATA=1, else undefined.
//    First edge after deassert: in_ready=1.
//  - SKID_EN=1: states EMPTY(0), ONE(main), TWO(main+skid). in_ready = !skid_v, registered.
//    EMPTY: in xfer -> ONE, main<=in_data.
//    ONE: in & out -> ONE, main<=in; out only -> EMPTY; in only -> TWO, skid<=in_data.
//    TWO: out xfer -> ONE, main<=skid, skid_v<=0; no in xfer possible (in_ready=0).
//    Order always preserved; skid never bypasses main.
//  - SKID_EN=0: in_ready = out_ready || !out_valid (combinational). No TWO state.
//  - out_data holds stable while out_valid && !out_ready (no change without out xfer).
//  - flush: synchronous, highest priority. Next cycle main_v=skid_v=0, occupancy=0.
//    Out xfer in the flush cycle completes normally. Input accepted in the flush cycle is
//    discarded. in_ready=1 the cycle after flush.
//  - stall_cnt: +1 per cycle with out_valid&&!out_ready; saturates at 2^CNT_W-1, no wrap;
//    stall_clr has priority over increment; flush does not clear it.
//  - Reset mid-operation: all entries dropped immediately, no partial output.
//  - Payload opaque: no field decoding, no width conversion; payload transferred bit-exact.
// STRUCTURE
//  - pipe_pkg: mem_wb_payload_t packed struct {alu_result[63:0], mem_data[63:0],
//    rd_idx[4:0], reg_write, mem_to_reg[1:0], pc_plus4[63:0]}; MEM_WB_W=$bits(...)=200;
//    MTR_ALU=2'd0, MTR_MEM=2'd1, MTR_PC4=2'd2.
//  - Single module; generate on SKID_EN selects skid logic; RESET_DATA via generate on the
//    data flops. No sub-module.
// TESTING
//  1 reset held 3 cycles, release -> out_valid=0, occupancy=0, stall_cnt=0, in_ready=1
//    after 1st edge.
//  2 stream 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 in order, 1-cycle latency,
//    stall_cnt=0.
//  3 SKID_EN=1, out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB held, in_ready=0 after 2nd,
//    occupancy=2, 0xC not taken; out_ready=1 -> 0xA,0xB,0xC delivered.
//  4 occupancy=2 and flush=1 with in_valid=1 (0xD) -> next cycle occupancy=0,
//    out_valid=0, 0xD never appears.
//  5 out_valid=1, out_ready=0 for 70000 cycles, CNT_W=16 -> stall_cnt=65535;
//    stall_clr -> 0.
//  6 SKID_EN=0: out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 ->
//    in_ready=1 same cycle, pass-through.
//  7 reset asserted mid-stream with occupancy=2 -> out_valid=0 immediately (async),
//    stream restarts clean.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline payload types. The default elastic-stage payload is the packed MEM->WB bundle.
package pipe_pkg;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] mem_data;
    logic [4:0]  rd_idx;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [63:0] pc_plus4;
  } mem_wb_payload_t;

  localparam int MEM_WB_W = $bits(mem_wb_payload_t);

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

endpackage

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, synchronous flush, optional
// 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W  = MEM_WB_W,
  parameter bit SKID_EN    = 1'b1,
  parameter bit RESET_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_clr
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                 main_vld_p0;
  logic                 main_vld_nxt;
  logic [PAYLOAD_W-1:0] main_data_p0;
  logic [PAYLOAD_W-1:0] main_data_nxt;
  logic                 skid_vld_p0;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_vld_p0 && out_ready;
  assign out_valid = main_vld_p0;
  assign out_data  = main_data_p0;
  assign occupancy = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};

  if (SKID_EN) begin : g_skid
    logic                 skid_vld_nxt;
    logic [PAYLOAD_W-1:0] skid_data_p0;
    logic [PAYLOAD_W-1:0] skid_data_nxt;
    logic                 in_ready_p0;

    // The skid entry is always younger than main, so it only ever refills main.
    always_comb begin
      main_vld_nxt  = main_vld_p0;
      main_data_nxt = main_data_p0;
      skid_vld_nxt  = skid_vld_p0;
      skid_data_nxt = skid_data_p0;
      if (!main_vld_p0) begin
        if (in_fire) begin
          main_vld_nxt  = 1'b1;
          main_data_nxt = in_data;
        end
      end else if (!skid_vld_p0) begin
        if (in_fire && out_fire) begin
          main_data_nxt = in_data;
        end else if (out_fire) begin
          main_vld_nxt = 1'b0;
        end else if (in_fire) begin
          skid_vld_nxt  = 1'b1;
          skid_data_nxt = in_data;
        end
      end else if (out_fire) begin
        main_data_nxt = skid_data_p0;
        skid_vld_nxt  = 1'b0;
      end
      if (flush) begin
        main_vld_nxt = 1'b0;
        skid_vld_nxt = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        skid_vld_p0 <= 1'b0;
        in_ready_p0 <= 1'b0;
      end else begin
        skid_vld_p0 <= skid_vld_nxt;
        in_ready_p0 <= !skid_vld_nxt;
      end
    end

    if (RESET_DATA) begin : g_skid_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset) skid_data_p0 <= '0;
        else       skid_data_p0 <= skid_data_nxt;
      end
    end else begin : g_skid_nrst
      always_ff @(posedge clk) skid_data_p0 <= skid_data_nxt;
    end

    assign in_ready = in_ready_p0;
  end else begin : g_noskid
    always_comb begin
      main_vld_nxt  = main_vld_p0;
      main_data_nxt = main_data_p0;
      if (in_fire) begin
        main_vld_nxt  = 1'b1;
        main_data_nxt = in_data;
      end else if (out_fire) begin
        main_vld_nxt = 1'b0;
      end
      if (flush) main_vld_nxt = 1'b0;
    end

    assign skid_vld_p0 = 1'b0;
    assign in_ready    = out_ready || !main_vld_p0;
  end

  // Stage p0: output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) main_vld_p0 <= 1'b0;
    else       main_vld_p0 <= main_vld_nxt;
  end

  if (RESET_DATA) begin : g_main_rst
    always_ff @(posedge clk or posedge reset) begin
      if (reset) main_data_p0 <= '0;
      else       main_data_p0 <= main_data_nxt;
    end
  end else begin : g_main_nrst
    always_ff @(posedge clk) main_data_p0 <= main_data_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stall_cnt <= '0;
    else if (stall_clr)                 stall_cnt <= '0;
    else if (main_vld_p0 && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule
